// File: rtl/video_hv_counter_if.sv
// Beam-counter bus: pixel enable and flip request in, counters and timing flags out.
interface video_hv_counter_if #(
    parameter int CW = 9
) ();
    logic          CE;
    logic          FLIP;
    logic [CW-1:0] H;
    logic [CW-1:0] V;
    logic          HSYNC;
    logic          VSYNC;
    logic          HBLANK;
    logic          VBLANK;
    logic          LINE_END;
    logic          FRAME_END;
    logic          FLIP_Q;

    // Timing generator side
    modport master (
        input  CE, FLIP,
        output H, V, HSYNC, VSYNC, HBLANK, VBLANK, LINE_END, FRAME_END, FLIP_Q
    );

    // Display-chain side
    modport slave (
        output CE, FLIP,
        input  H, V, HSYNC, VSYNC, HBLANK, VBLANK, LINE_END, FRAME_END, FLIP_Q
    );
endinterface

// File: rtl/video_hv_counter.sv
// Video timing generator: H/V beam counters with registered sync, blank,
// line/frame-end flags and a frame-aligned flip-screen control.
module video_hv_counter #(
    parameter int CW       = 9,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 244,
    parameter int VS_END   = 248
) (
    input  logic                CLK,
    input  logic                RST,
    video_hv_counter_if.master  bus
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Timing windows must be ordered and fit in the counter width.
    generate
        if (!(H_ACTIVE < HS_START && HS_START < HS_END && HS_END <= H_TOTAL &&
              H_TOTAL <= (1 << CW))) begin : g_bad_h
            $error("video_hv_counter: illegal horizontal timing parameters");
        end
        if (!(V_ACTIVE < VS_START && VS_START < VS_END && VS_END <= V_TOTAL &&
              V_TOTAL <= (1 << CW))) begin : g_bad_v
            $error("video_hv_counter: illegal vertical timing parameters");
        end
    endgenerate

    // Zero-extended compare so an upper bound of 2^CW still works.
    function automatic logic in_span(input logic [CW-1:0] c, input int lo, input int hi);
        int ci;
        ci = int'({1'b0, c});
        return (ci >= lo) && (ci < hi);
    endfunction

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          hb_q, hb_d;
    logic          vb_q, vb_d;
    logic          le_q, le_d;
    logic          fe_q, fe_d;
    logic          flip_q, flip_d;

    // Next count, flip capture at the frame wrap, and flags decoded from the
    // next count so they land on the same edge as H/V.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        flip_d = flip_q;
        if (bus.CE) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d    = '0;
                    flip_d = bus.FLIP;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        hs_d = in_span(h_d, HS_START, HS_END);
        vs_d = in_span(v_d, VS_START, VS_END);
        hb_d = in_span(h_d, H_ACTIVE, H_TOTAL);
        vb_d = in_span(v_d, V_ACTIVE, V_TOTAL);
        le_d = (h_d == H_LAST);
        fe_d = (h_d == H_LAST) && (v_d == V_LAST);
    end

    // State and flag registers; with CE=0 the next state equals the current one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            hb_q   <= 1'b0;
            vb_q   <= 1'b0;
            le_q   <= 1'b0;
            fe_q   <= 1'b0;
            flip_q <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hb_q   <= hb_d;
            vb_q   <= vb_d;
            le_q   <= le_d;
            fe_q   <= fe_d;
            flip_q <= flip_d;
        end
    end

    assign bus.H         = h_q;
    assign bus.V         = v_q;
    assign bus.HSYNC     = hs_q;
    assign bus.VSYNC     = vs_q;
    assign bus.HBLANK    = hb_q;
    assign bus.VBLANK    = vb_q;
    assign bus.LINE_END  = le_q;
    assign bus.FRAME_END = fe_q;
    assign bus.FLIP_Q    = flip_q;

endmodule

// File: tb/tb_video_hv_counter.sv
// Bench for video_hv_counter: a default-timing instance (A) for reset, line
// and CE-gating checks and a small-timing instance (B) for frame wrap and flip.
module tb_video_hv_counter;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       le;
        logic       fe;
        logic       fq;
    } out_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    video_hv_counter_if #(.CW(9)) ifa ();
    video_hv_counter_if #(.CW(9)) ifb ();

    video_hv_counter dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (ifa.master)
    );

    video_hv_counter #(
        .CW(9), .H_TOTAL(8), .H_ACTIVE(4), .HS_START(5), .HS_END(7),
        .V_TOTAL(4), .V_ACTIVE(2), .VS_START(3), .VS_END(4)
    ) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (ifb.master)
    );

    out_t act_a, act_b;
    assign act_a = {ifa.H, ifa.V, ifa.HSYNC, ifa.VSYNC, ifa.HBLANK, ifa.VBLANK,
                    ifa.LINE_END, ifa.FRAME_END, ifa.FLIP_Q};
    assign act_b = {ifb.H, ifb.V, ifb.HSYNC, ifb.VSYNC, ifb.HBLANK, ifb.VBLANK,
                    ifb.LINE_END, ifb.FRAME_END, ifb.FLIP_Q};

    // Reference: position in frame as a plain CE-edge count; all outputs derive from it.
    function automatic out_t mdl(input int n, input int ht, input int ha, input int hs0,
                                 input int hs1, input int vt, input int va, input int vs0,
                                 input int vs1, input logic fq);
        out_t o;
        int h, v;
        h    = n % ht;
        v    = (n / ht) % vt;
        o.h  = 9'(h);
        o.v  = 9'(v);
        o.hs = (h >= hs0) && (h < hs1);
        o.vs = (v >= vs0) && (v < vs1);
        o.hb = (h >= ha);
        o.vb = (v >= va);
        o.le = (h == ht - 1);
        o.fe = (h == ht - 1) && (v == vt - 1);
        o.fq = fq;
        return o;
    endfunction

    int   n_a = 0, n_b = 0;
    logic fm_a = 1'b0, fm_b = 1'b0;

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            n_a  = 0;
            fm_a = 1'b0;
        end else if (ifa.CE) begin
            if (n_a == 384 * 264 - 1) begin
                n_a  = 0;
                fm_a = ifa.FLIP;
            end else begin
                n_a = n_a + 1;
            end
        end
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            n_b  = 0;
            fm_b = 1'b0;
        end else if (ifb.CE) begin
            if (n_b == 8 * 4 - 1) begin
                n_b  = 0;
                fm_b = ifb.FLIP;
            end else begin
                n_b = n_b + 1;
            end
        end
    end

    task automatic cmp(input string nm, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got H=%0d V=%0d hs=%b vs=%b hb=%b vb=%b le=%b fe=%b fq=%b, want H=%0d V=%0d hs=%b vs=%b hb=%b vb=%b le=%b fe=%b fq=%b",
                     nm, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.le, got.fe, got.fq,
                     exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.le, exp.fe, exp.fq);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp("model_A", act_a, mdl(n_a, 384, 256, 288, 320, 264, 240, 244, 248, fm_a));
        cmp("model_B", act_b, mdl(n_b, 8, 4, 5, 7, 4, 2, 3, 4, fm_b));
    end

    task automatic edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    int fe_cnt;

    initial begin
        ifa.CE = 1'b1; ifa.FLIP = 1'b0;
        ifb.CE = 1'b0; ifb.FLIP = 1'b0;

        // ---- Instance A: reset state and first edge
        edges(1);
        chk("rst_H", ifa.H, 0);
        chk("rst_flags", int'(act_a[6:0]), 0);
        #2 rst_a = 1'b0;
        edges(1);
        chk("first_H", ifa.H, 1);
        chk("first_V", ifa.V, 0);

        // ---- Reset mid-frame at H=100 V=50
        edges(50 * 384 + 100 - 1);
        chk("pos_H100", ifa.H, 100);
        chk("pos_V50", ifa.V, 50);
        #2 rst_a = 1'b1;
        #1 chk("async_rst_all", int'(act_a), 0);
        #1 rst_a = 1'b0;
        edges(1);
        chk("post_rst_H", ifa.H, 1);
        chk("post_rst_V", ifa.V, 0);

        // ---- Line sweep
        edges(254);
        chk("H255_hblank", ifa.HBLANK, 0);
        edges(1);
        chk("H256_H", ifa.H, 256);
        chk("H256_hblank", ifa.HBLANK, 1);
        edges(31);
        chk("H287_hsync", ifa.HSYNC, 0);
        edges(1);
        chk("H288_hsync", ifa.HSYNC, 1);
        edges(31);
        chk("H319_hsync", ifa.HSYNC, 1);
        edges(1);
        chk("H320_hsync", ifa.HSYNC, 0);
        edges(62);
        chk("H382_le", ifa.LINE_END, 0);
        edges(1);
        chk("H383_le", ifa.LINE_END, 1);
        edges(1);
        chk("wrap_H", ifa.H, 0);
        chk("wrap_V", ifa.V, 1);
        chk("wrap_hblank", ifa.HBLANK, 0);
        chk("wrap_le", ifa.LINE_END, 0);

        // ---- CE every third edge: one line takes 1152 edges
        for (int i = 0; i < 1152; i++) begin
            ifa.CE = (i % 3 == 0);
            @(negedge clk);
            if (i == 0) chk("ce_step_H", ifa.H, 1);
            if (i == 2) chk("ce_hold_H", ifa.H, 1);
        end
        chk("ce_line_H", ifa.H, 0);
        chk("ce_line_V", ifa.V, 2);
        ifa.CE = 1'b1;

        // ---- Instance B: frame wrap
        #2 rst_b = 1'b0;
        ifb.CE = 1'b1;
        edges(31);
        chk("B_last_H", ifb.H, 7);
        chk("B_last_V", ifb.V, 3);
        chk("B_last_fe", ifb.FRAME_END, 1);
        chk("B_last_vb", ifb.VBLANK, 1);
        chk("B_last_vs", ifb.VSYNC, 1);
        edges(1);
        chk("B_wrap_HV", int'({ifb.H, ifb.V}), 0);
        chk("B_wrap_vb", ifb.VBLANK, 0);
        chk("B_wrap_fe", ifb.FRAME_END, 0);

        // ---- Flip alignment
        edges(10);
        ifb.FLIP = 1'b1;
        edges(21);
        chk("flip_hold", ifb.FLIP_Q, 0);
        edges(1);
        chk("flip_load", ifb.FLIP_Q, 1);
        edges(10);
        ifb.FLIP = 1'b0;
        edges(3);
        ifb.FLIP = 1'b1;
        edges(19);
        chk("flip_pulse_lost", ifb.FLIP_Q, 1);
        ifb.FLIP = 1'b0;
        edges(32);
        chk("flip_clear", ifb.FLIP_Q, 0);

        // ---- FRAME_END once per 32 CE edges over three frames
        fe_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (ifb.FRAME_END) fe_cnt++;
        end
        chk("fe_count_3frames", fe_cnt, 3);

        // ---- Gated CE on B, model keeps checking
        for (int i = 0; i < 70; i++) begin
            ifb.CE = (i % 2 == 0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_hv_counter.md
# video_hv_counter

Video timing generator that produces the horizontal and vertical beam counters, sync, and blanking for the display chain. It replaces the cascaded LS161/LS163 counter chips of the original board with one synchronous block. Its H and V count bits, plus the frame-aligned flip control, feed the ls86 XOR stage directly downstream, which produces the flip-screen address bits.

## Interface

Parameters:
- CW, 9, counter width in bits for H and V
- H_TOTAL, 384, pixel clocks per line
- H_ACTIVE, 256, visible pixels per line; HBLANK is asserted for H ≥ H_ACTIVE
- HS_START, 288, first H count with HSYNC asserted
- HS_END, 320, first H count with HSYNC deasserted
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 240, visible lines; VBLANK is asserted for V ≥ V_ACTIVE
- VS_START, 244, first V count with VSYNC asserted
- VS_END, 248, first V count with VSYNC deasserted

Ports:
- CLK  in  1  master clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CE  in  1  pixel clock enable; the block advances only on CLK edges with CE=1
- FLIP  in  1  flip-screen request from the control latch
- H  out  CW  horizontal count
- V  out  CW  vertical count
- HSYNC  out  1  horizontal sync, active-high
- VSYNC  out  1  vertical sync, active-high
- HBLANK  out  1  horizontal blank
- VBLANK  out  1  vertical blank
- LINE_END  out  1  high while H = H_TOTAL-1
- FRAME_END  out  1  high while H = H_TOTAL-1 and V = V_TOTAL-1
- FLIP_Q  out  1  flip control, changes only at the frame boundary; feeds the downstream XOR stage

## Operation

- Reset: RST=1 immediately forces all outputs low: H=0, V=0, HSYNC=0, VSYNC=0, HBLANK=0, VBLANK=0, LINE_END=0, FRAME_END=0, FLIP_Q=0.
- Reset deassertion: counting starts at the first CE=1 edge after RST falls.
- H counter, on each CE=1 edge:
  - H < H_TOTAL-1: H increments by 1.
  - H = H_TOTAL-1: H wraps to 0.
- V counter: advances only on the CE=1 edge where H wraps.
  - V < V_TOTAL-1: V increments by 1.
  - V = V_TOTAL-1: V wraps to 0.
- Sync and blank flags:
  - HSYNC = 1 for HS_START ≤ H < HS_END.
  - VSYNC = 1 for VS_START ≤ V < VS_END.
  - HBLANK = 1 for H ≥ H_ACTIVE.
  - VBLANK = 1 for V ≥ V_ACTIVE.
- All flags are registered. They are computed from the next-state count so they change on the same edge as H/V, with no skew and no combinational path from the counters to the outputs.
- LINE_END and FRAME_END are registered the same way and are aligned with the count they describe.
- FLIP_Q loads FLIP on the CE=1 edge where H and V both wrap to 0. FLIP changes at any other time are ignored until the next frame boundary. A FLIP pulse that returns to its old value before the boundary is lost.
- CE=0: all registers hold and no outputs change.
- Arithmetic: unsigned, modulo as defined above. Counts never reach H_TOTAL or V_TOTAL.
- Parameter legality, checked by a simulation-only elaboration assertion:
  - H_ACTIVE < HS_START < HS_END ≤ H_TOTAL ≤ 2^CW
  - V_ACTIVE < VS_START < VS_END ≤ V_TOTAL ≤ 2^CW
- No state machine beyond the two counters and FLIP_Q.

## Timing

- Latency: outputs reflect a counter update on the same CLK edge that performs it.
- Line length: H_TOTAL CE-qualified edges. Frame length: H_TOTAL × V_TOTAL = 101376 CE edges at defaults.
- Simultaneous events: on the edge where H = H_TOTAL-1 and V = V_TOTAL-1 with CE=1, the following all happen on that one edge:
  - H → 0 and V → 0
  - FLIP_Q ← FLIP
  - LINE_END and FRAME_END fall
  - HBLANK falls
  - VBLANK falls (at defaults)
- RST mid-line: the asynchronous reset overrides CE and any in-progress wrap. Outputs go to reset values before the next CLK edge.
- CE may be any duty cycle, including tied high.

## Test plan

- Reset mid-frame: run to H=100, V=50, pulse RST asynchronously between edges. All outputs are 0 before the next edge. With CE=1 after release, the first edge gives H=1, V=0.
- Line sweep, CE=1: H counts 0..383 then returns to 0 and V steps 0→1.
  - HBLANK rises on the edge to H=256 and falls on the edge to H=0.
  - HSYNC is high for H=288..319 exactly.
  - LINE_END is high only at H=383.
- Frame wrap: at H=383, V=263 with CE=1, one edge gives H=0, V=0, VBLANK=0, FRAME_END 1→0.
  - VSYNC is high for V=244..247.
  - VBLANK is high for V=240..263.
- CE gating: CE=1 on every third edge. H advances exactly once per three edges and nothing toggles while CE=0. One line takes 1152 edges.
- Flip alignment: drive FLIP=1 at V=10. FLIP_Q stays 0 until the frame-wrap edge, then becomes 1. FLIP 0→1→0 within one frame leaves FLIP_Q unchanged.
- Small-parameter frame: set H_TOTAL=8, H_ACTIVE=4, HS 5..6, V_TOTAL=4, V_ACTIVE=2, VS 3..3. Run three frames and compare every output each edge against a reference model. FRAME_END occurs every 32 CE edges.
